// File: rtl/stoch_vec_decode.sv
// Stochastic-to-binary decoder: counts ones per lane over WINDOW accepted samples
// and presents each window's counts through a single valid/ready output register.
module stoch_vec_decode #(
  parameter  int unsigned VEC_LEN = 2,
  parameter  int unsigned WINDOW  = 256,
  localparam int unsigned CW      = $clog2(WINDOW + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [VEC_LEN-1:0]    x,
  output logic [VEC_LEN*CW-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int unsigned SW = $clog2(WINDOW);

  logic [CW-1:0]         r_acc [VEC_LEN];
  logic [SW-1:0]         r_smp;
  logic [VEC_LEN*CW-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;

  logic [CW-1:0]         w_sum [VEC_LEN];
  logic [VEC_LEN*CW-1:0] w_final;
  logic                  w_done;

  // Running count including the current bit; at completion this is the final count.
  always_comb begin
    w_final = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      w_sum[i] = r_acc[i] + CW'(x[i]);
      w_final[i*CW +: CW] = w_sum[i];
    end
  end

  assign w_done = en && (r_smp == SW'(WINDOW - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_smp     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) r_acc[i] <= '0;
    end else begin
      if (en) begin
        // Window wrap clears accumulators on the same edge so no sample is lost.
        if (w_done) begin
          r_smp <= '0;
          for (int i = 0; i < VEC_LEN; i++) r_acc[i] <= '0;
        end else begin
          r_smp <= SW'(r_smp + 1'b1);
          for (int i = 0; i < VEC_LEN; i++) r_acc[i] <= w_sum[i];
        end
      end
      if (w_done) begin
        if (!r_valid || out_ready) begin
          r_data  <= w_final;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_stoch_vec_decode.sv
// Self-checking bench for stoch_vec_decode: table-driven windows with a scoreboard
// queue, plus directed sequences for overrun, simultaneous handshake and reset.
module tb_stoch_vec_decode;

  localparam int unsigned VEC_LEN = 2;
  localparam int unsigned WINDOW  = 256;
  localparam int unsigned CW      = 9;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  en;
  logic [VEC_LEN-1:0]    x;
  logic [VEC_LEN*CW-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overrun;

  stoch_vec_decode #(.VEC_LEN(VEC_LEN), .WINDOW(WINDOW)) dut (
    .CLK(CLK), .RST(RST), .en(en), .x(x),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int mode;
    int exp0;
    int exp1;
  } vec_t;

  typedef struct {
    int l0;
    int l1;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input int i);
    lane = int'(out_data[i*CW +: CW]);
  endfunction

  // Handshake about to happen on the coming edge: compare against oldest expected.
  task automatic consume();
    res_t r;
    if (sb.size() == 0) begin
      chk("unexpected_output", 1, 0);
    end else begin
      r = sb.pop_front();
      chk("sb_lane0", lane(0), r.l0);
      chk("sb_lane1", lane(1), r.l1);
    end
  endtask

  task automatic step(input logic e, input logic [1:0] xv, input logic rdy);
    en = e; x = xv; out_ready = rdy;
    if (out_valid && rdy) consume();
    @(posedge CLK); #1;
  endtask

  function automatic logic [1:0] pat(input int mode, input int i);
    logic [1:0] v;
    case (mode)
      0, 2:    v = 2'b01;
      1:       v = {1'(i % 4 == 0), 1'(i % 2 == 0)};
      3:       v = {1'(i % 3 == 0), 1'(i < 100)};
      4:       v = 2'b11;
      default: v = 2'b00;
    endcase
    pat = v;
  endfunction

  // One full window; expected result pushed when the completing sample is driven.
  task automatic run_window(input int mode, input logic rdy, input logic rdy_last,
                            input logic push, input int e0, input int e1);
    res_t r;
    for (int i = 0; i < int'(WINDOW); i++) begin
      if (mode == 2) step(1'b0, 2'b11, rdy);
      if (i == int'(WINDOW) - 1) begin
        if (push) begin
          r.l0 = e0; r.l1 = e1;
          sb.push_back(r);
        end
        step(1'b1, pat(mode, i), rdy_last);
      end else begin
        step(1'b1, pat(mode, i), rdy);
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    RST = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{0, 256, 0};
    tbl[1] = '{1, 128, 64};
    tbl[2] = '{1, 128, 64};
    tbl[3] = '{2, 256, 0};
    tbl[4] = '{3, 100, 86};
    tbl[5] = '{4, 256, 256};
    tbl[6] = '{5, 0, 0};

    en = 1'b0; x = '0; out_ready = 1'b0;
    do_reset();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_overrun", int'(overrun), 0);

    // Back-to-back windows with out_ready held high: no loss, one pulse per window.
    foreach (tbl[k]) begin
      run_window(tbl[k].mode, 1'b1, 1'b1, 1'b1, tbl[k].exp0, tbl[k].exp1);
      chk("tbl_valid", int'(out_valid), 1);
      chk("tbl_overrun", int'(overrun), 0);
    end
    step(1'b0, 2'b00, 1'b1);
    chk("tbl_drained_valid", int'(out_valid), 0);

    // en=0 on the would-be completion cycle must not complete the window.
    do_reset();
    for (int i = 0; i < int'(WINDOW) - 1; i++) step(1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b11, 1'b1);
    chk("hold_no_valid", int'(out_valid), 0);
    sb.push_back('{255, 0});
    step(1'b1, 2'b00, 1'b1);
    chk("hold_valid", int'(out_valid), 1);
    step(1'b0, 2'b00, 1'b1);

    // Two completions with out_ready low: second window dropped, overrun sticks.
    do_reset();
    run_window(0, 1'b0, 1'b0, 1'b1, 256, 0);
    chk("ovr_w1_valid", int'(out_valid), 1);
    chk("ovr_w1_lane0", lane(0), 256);
    chk("ovr_w1_overrun", int'(overrun), 0);
    run_window(5, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("ovr_w2_lane0", lane(0), 256);
    chk("ovr_w2_overrun", int'(overrun), 1);
    step(1'b0, 2'b00, 1'b1);
    chk("ovr_ack_valid", int'(out_valid), 0);
    chk("ovr_ack_overrun", int'(overrun), 1);
    step(1'b0, 2'b00, 1'b0);
    chk("ovr_sticky", int'(overrun), 1);

    // Handshake on the same edge as completion: new data loads, no overrun.
    do_reset();
    chk("rst2_overrun", int'(overrun), 0);
    run_window(0, 1'b0, 1'b0, 1'b1, 256, 0);
    run_window(3, 1'b0, 1'b1, 1'b1, 100, 86);
    chk("sim_valid", int'(out_valid), 1);
    chk("sim_lane0", lane(0), 100);
    chk("sim_overrun", int'(overrun), 0);
    step(1'b0, 2'b00, 1'b1);
    chk("sim_drained", int'(out_valid), 0);

    // Reset mid-window discards the partial count.
    for (int i = 0; i < 100; i++) step(1'b1, 2'b11, 1'b1);
    RST = 1'b1;
    step(1'b1, 2'b11, 1'b1);
    RST = 1'b0;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    for (int i = 0; i < int'(WINDOW) - 1; i++) step(1'b1, 2'b11, 1'b0);
    chk("mid_rst_early", int'(out_valid), 0);
    sb.push_back('{256, 256});
    step(1'b1, 2'b11, 1'b0);
    chk("mid_rst_valid_after", int'(out_valid), 1);
    chk("mid_rst_lane0", lane(0), 256);
    step(1'b0, 2'b00, 1'b1);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
